// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared CPU definitions: RV32I major opcodes, hazard controller states and the
// register-usage helpers that the hazard detector and the forwarding unit agree on.
package pipeline_hazard_controller_pkg;

    localparam logic [6:0] OP_LUI                  = 7'b0110111;
    localparam logic [6:0] OP_AUIPC                = 7'b0010111;
    localparam logic [6:0] OP_JAL                  = 7'b1101111;
    localparam logic [6:0] OP_JALR                 = 7'b1100111;
    localparam logic [6:0] OP_BRANCH               = 7'b1100011;
    localparam logic [6:0] OP_LOAD                 = 7'b0000011;
    localparam logic [6:0] OP_STORE                = 7'b0100011;
    localparam logic [6:0] OP_ARITHMETIC_IMMEDIATE = 7'b0010011;
    localparam logic [6:0] OP_ARITHMETIC           = 7'b0110011;

    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LOAD_USE = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_FLUSH    = 2'd3
    } hazard_state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_ARITHMETIC) || (opcode == OP_ARITHMETIC_IMMEDIATE) ||
               (opcode == OP_LOAD)       || (opcode == OP_STORE) ||
               (opcode == OP_BRANCH)     || (opcode == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_ARITHMETIC) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline stage registers and the hazard controller.
// The controller takes the slave side; the pipeline datapath (or a bench) the master side.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic             de_valid;
    logic [6:0]       de_opcode;
    logic [4:0]       de_rs1;
    logic [4:0]       de_rs2;
    logic             ex_valid;
    logic [6:0]       ex_opcode;
    logic [4:0]       ex_rd;
    logic             redirect;
    logic             mem_busy;
    logic             perf_clear;

    logic             stall_fetch;
    logic             stall_decode;
    logic             bubble_execute;
    logic             stall_backend;
    logic             flush_fetch;
    logic             flush_decode;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output de_valid, de_opcode, de_rs1, de_rs2,
        output ex_valid, ex_opcode, ex_rd,
        output redirect, mem_busy, perf_clear,
        input  stall_fetch, stall_decode, bubble_execute, stall_backend,
        input  flush_fetch, flush_decode, stall_cycles, flush_events
    );

    modport slave (
        input  de_valid, de_opcode, de_rs1, de_rs2,
        input  ex_valid, ex_opcode, ex_rd,
        input  redirect, mem_busy, perf_clear,
        output stall_fetch, stall_decode, bubble_execute, stall_backend,
        output flush_fetch, flush_decode, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and the
// count sticks at all-ones instead of wrapping.
module pipeline_hazard_controller_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use interlock, data-memory wait stalls and
// front-end flushes after redirects, plus saturating stall/flush counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_controller_if.slave  hz
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hazard_state_e          r_state;
    hazard_state_e          w_nextState;
    logic [FLUSH_CNT_W-1:0] r_flushCnt;
    logic [FLUSH_CNT_W-1:0] w_nextFlushCnt;
    logic                   r_pendFlush;
    logic                   w_nextPendFlush;

    logic                   w_hazard;
    logic                   w_startFlush;
    logic                   w_stallFetch;
    logic                   w_stallDecode;
    logic                   w_bubbleExecute;
    logic                   w_stallBackend;
    logic                   w_flushFront;
    logic [CNT_W-1:0]       w_stallCount;
    logic [CNT_W-1:0]       w_flushCount;

    // x0 is hardwired to zero, so a load targeting it never blocks a consumer.
    always_comb begin
        w_hazard = hz.ex_valid && (hz.ex_opcode == OP_LOAD) && (hz.ex_rd != 5'd0) && hz.de_valid &&
                   ((uses_rs1(hz.de_opcode) && (hz.de_rs1 == hz.ex_rd)) ||
                    (uses_rs2(hz.de_opcode) && (hz.de_rs2 == hz.ex_rd)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flushCnt  <= '0;
            r_pendFlush <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_flushCnt  <= w_nextFlushCnt;
            r_pendFlush <= w_nextPendFlush;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextFlushCnt  = r_flushCnt;
        w_nextPendFlush = r_pendFlush;
        w_startFlush    = 1'b0;
        w_stallFetch    = 1'b0;
        w_stallDecode   = 1'b0;
        w_bubbleExecute = 1'b0;
        w_stallBackend  = 1'b0;
        w_flushFront    = 1'b0;

        unique case (r_state)
            S_RUN, S_LOAD_USE: begin
                if (hz.mem_busy) begin
                    w_stallFetch    = 1'b1;
                    w_stallDecode   = 1'b1;
                    w_stallBackend  = 1'b1;
                    w_nextPendFlush = r_pendFlush | hz.redirect;
                    w_nextState     = S_MEM_WAIT;
                end else if (hz.redirect) begin
                    w_startFlush = 1'b1;
                end else if (w_hazard && (r_state == S_RUN)) begin
                    w_stallFetch    = 1'b1;
                    w_stallDecode   = 1'b1;
                    w_bubbleExecute = 1'b1;
                    w_nextState     = S_LOAD_USE;
                end else begin
                    w_nextState = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (hz.mem_busy) begin
                    w_stallFetch    = 1'b1;
                    w_stallDecode   = 1'b1;
                    w_stallBackend  = 1'b1;
                    w_nextPendFlush = r_pendFlush | hz.redirect;
                end else begin
                    w_nextState = S_RUN;
                    if (r_pendFlush || hz.redirect) begin
                        w_startFlush    = 1'b1;
                        w_nextPendFlush = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                // The front end is being discarded anyway, so memory waits only freeze the back end.
                w_flushFront   = 1'b1;
                w_stallBackend = hz.mem_busy;
                if (hz.redirect) begin
                    w_startFlush = 1'b1;
                end else begin
                    w_nextFlushCnt = r_flushCnt - 1'b1;
                    if (w_nextFlushCnt == '0) begin
                        w_nextState = S_RUN;
                    end
                end
            end
            default: begin
                w_nextState = S_RUN;
            end
        endcase

        if (w_startFlush) begin
            w_flushFront = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_nextFlushCnt = FLUSH_RELOAD;
                w_nextState    = S_FLUSH;
            end else begin
                w_nextFlushCnt = '0;
                w_nextState    = S_RUN;
            end
        end
    end

    assign hz.stall_fetch    = w_stallFetch    & ~rst;
    assign hz.stall_decode   = w_stallDecode   & ~rst;
    assign hz.bubble_execute = w_bubbleExecute & ~rst;
    assign hz.stall_backend  = w_stallBackend  & ~rst;
    assign hz.flush_fetch    = w_flushFront    & ~rst;
    assign hz.flush_decode   = w_flushFront    & ~rst;

    pipeline_hazard_controller_sat_counter #(.CNT_W(CNT_W)) u_stallCounter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (hz.stall_fetch),
        .i_clr   (hz.perf_clear),
        .o_count (w_stallCount)
    );

    pipeline_hazard_controller_sat_counter #(.CNT_W(CNT_W)) u_flushCounter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_startFlush),
        .i_clr   (hz.perf_clear),
        .o_count (w_flushCount)
    );

    assign hz.stall_cycles = w_stallCount;
    assign hz.flush_events = w_flushCount;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized self-checking bench for pipeline_hazard_controller; expectations come
// from a cycle-level model of the stall/flush rules kept in this file.
module tb_pipeline_hazard_controller;
    import pipeline_hazard_controller_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(CNT_W)) hzIf ();

    pipeline_hazard_controller #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hzIf)
    );

    int vectors    = 0;
    int miscompares = 0;

    int              mFlushLeft;
    bit              mWaiting;
    bit              mPending;
    bit              mBubbled;
    longint unsigned mStallCnt;
    longint unsigned mFlushCnt;

    logic [6:0] opList [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                               OP_LOAD, OP_STORE, OP_ARITHMETIC_IMMEDIATE, OP_ARITHMETIC};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic bit modelHazard(input bit dv, input logic [6:0] dop, input logic [4:0] r1,
                                       input logic [4:0] r2, input bit ev, input logic [6:0] eop,
                                       input logic [4:0] erd);
        bit readsA = dop inside {OP_ARITHMETIC, OP_ARITHMETIC_IMMEDIATE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
        bit readsB = dop inside {OP_ARITHMETIC, OP_STORE, OP_BRANCH};
        return ev && (eop == OP_LOAD) && (erd != 0) && dv && ((readsA && r1 == erd) || (readsB && r2 == erd));
    endfunction

    // One clock cycle: drive, predict and check the combinational controls, then the counters after the edge.
    task automatic applyStimulus(input bit r, input bit dv, input logic [6:0] dop, input logic [4:0] r1,
                                 input logic [4:0] r2, input bit ev, input logic [6:0] eop,
                                 input logic [4:0] erd, input bit rd, input bit mb, input bit pc);
        bit eSF = 0, eSD = 0, eBE = 0, eSB = 0, eFL = 0, accepted = 0, nextBubbled = 0;
        @(negedge clk);
        rst = r;
        hzIf.de_valid = dv;  hzIf.de_opcode = dop; hzIf.de_rs1 = r1; hzIf.de_rs2 = r2;
        hzIf.ex_valid = ev;  hzIf.ex_opcode = eop; hzIf.ex_rd = erd;
        hzIf.redirect = rd;  hzIf.mem_busy = mb;   hzIf.perf_clear = pc;
        #1;
        if (r) begin
            mFlushLeft = 0; mWaiting = 0; mPending = 0; mBubbled = 0;
            mStallCnt = 0;  mFlushCnt = 0;
        end else begin
            if (mFlushLeft > 0) begin
                eFL = 1; eSB = mb;
                if (rd) begin accepted = 1; mFlushLeft = FLUSH_CYCLES - 1; end
                else mFlushLeft--;
            end else if (mb) begin
                eSF = 1; eSD = 1; eSB = 1;
                mPending = mPending | rd;
                mWaiting = 1;
            end else if (mWaiting || rd) begin
                mWaiting = 0;
                if (mPending || rd) begin
                    eFL = 1; accepted = 1; mPending = 0; mFlushLeft = FLUSH_CYCLES - 1;
                end
            end else if (!mBubbled && modelHazard(dv, dop, r1, r2, ev, eop, erd)) begin
                eSF = 1; eSD = 1; eBE = 1; nextBubbled = 1;
            end
            mBubbled = nextBubbled;
        end
        checkOutput("stall_fetch",    hzIf.stall_fetch,    eSF);
        checkOutput("stall_decode",   hzIf.stall_decode,   eSD);
        checkOutput("bubble_execute", hzIf.bubble_execute, eBE);
        checkOutput("stall_backend",  hzIf.stall_backend,  eSB);
        checkOutput("flush_fetch",    hzIf.flush_fetch,    eFL);
        checkOutput("flush_decode",   hzIf.flush_decode,   eFL);
        if (!r) begin
            if (pc) mStallCnt = 0;
            else if (eSF && mStallCnt < CNT_MAX) mStallCnt++;
            if (pc) mFlushCnt = 0;
            else if (accepted && mFlushCnt < CNT_MAX) mFlushCnt++;
        end
        @(posedge clk);
        #1;
        checkOutput("stall_cycles", hzIf.stall_cycles, mStallCnt);
        checkOutput("flush_events", hzIf.flush_events, mFlushCnt);
    endtask

    task automatic idleCycle(input bit rd, input bit mb, input bit pc);
        applyStimulus(0, 0, OP_ARITHMETIC, 5'd0, 5'd0, 0, OP_ARITHMETIC, 5'd0, rd, mb, pc);
    endtask

    initial begin
        rst = 1'b1;
        hzIf.de_valid = 0; hzIf.de_opcode = '0; hzIf.de_rs1 = '0; hzIf.de_rs2 = '0;
        hzIf.ex_valid = 0; hzIf.ex_opcode = '0; hzIf.ex_rd = '0;
        hzIf.redirect = 0; hzIf.mem_busy = 0;   hzIf.perf_clear = 0;

        // Reset with redirect and mem_busy active: everything must stay quiet.
        applyStimulus(1, 1, OP_ARITHMETIC, 5'd5, 5'd5, 1, OP_LOAD, 5'd5, 1, 1, 0);
        checkOutput("reset_stall_cycles", hzIf.stall_cycles, 0);
        idleCycle(0, 0, 0);

        // Load-use on rs2, then an attempt through x0, then an unused rs2.
        applyStimulus(0, 1, OP_ARITHMETIC, 5'd3, 5'd5, 1, OP_LOAD, 5'd5, 0, 0, 0);
        checkOutput("loaduse_stall", hzIf.stall_fetch, 0);
        applyStimulus(0, 1, OP_ARITHMETIC, 5'd3, 5'd5, 0, OP_LOAD, 5'd5, 0, 0, 0);
        checkOutput("loaduse_count", hzIf.stall_cycles, 1);
        applyStimulus(0, 1, OP_ARITHMETIC, 5'd0, 5'd3, 1, OP_LOAD, 5'd0, 0, 0, 0);
        applyStimulus(0, 1, OP_ARITHMETIC_IMMEDIATE, 5'd1, 5'd7, 1, OP_LOAD, 5'd7, 0, 0, 0);
        checkOutput("nonuse_count", hzIf.stall_cycles, 1);

        // Single redirect, then back-to-back redirects.
        idleCycle(1, 0, 0);
        idleCycle(0, 0, 0);
        idleCycle(0, 0, 0);
        checkOutput("redirect_events", hzIf.flush_events, 1);
        idleCycle(1, 0, 0);
        idleCycle(1, 0, 0);
        idleCycle(0, 0, 0);
        idleCycle(0, 0, 0);
        checkOutput("redirect2_events", hzIf.flush_events, 3);

        // Four-cycle memory wait with a redirect in its second cycle.
        idleCycle(0, 0, 1);
        idleCycle(0, 1, 0);
        idleCycle(1, 1, 0);
        idleCycle(0, 1, 0);
        idleCycle(0, 1, 0);
        checkOutput("memwait_count", hzIf.stall_cycles, 4);
        idleCycle(0, 0, 0);
        checkOutput("memwait_release_events", hzIf.flush_events, 1);
        idleCycle(0, 0, 0);
        idleCycle(0, 0, 0);

        // Saturation and clear-over-increment.
        @(negedge clk);
        force dut.u_stallCounter.r_count = {CNT_W{1'b1}};
        #1;
        release dut.u_stallCounter.r_count;
        mStallCnt = CNT_MAX;
        idleCycle(0, 1, 0);
        checkOutput("saturate_hold", hzIf.stall_cycles, CNT_MAX);
        idleCycle(0, 1, 1);
        checkOutput("clear_over_inc", hzIf.stall_cycles, 0);
        idleCycle(0, 0, 0);

        // Asynchronous reset in the middle of a flush window.
        idleCycle(1, 0, 0);
        applyStimulus(1, 0, OP_ARITHMETIC, 5'd0, 5'd0, 0, OP_ARITHMETIC, 5'd0, 0, 0, 0);
        idleCycle(0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) < 1,
                          $urandom_range(0, 3) != 0,
                          opList[$urandom_range(0, 8)],
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) != 0) ? OP_LOAD : opList[$urandom_range(0, 8)],
                          5'($urandom_range(0, 3)),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
